// File: rtl/csr_regfile_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, field positions
// and reset values.
package csr_regfile_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIP_MTIP_BIT     = 7;

    // MXL=2 (64-bit) in the top two bits, extension letter I at bit 8.
    localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_0100;
    localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;

    // Read-only and unimplemented addresses silently drop writes.
    function automatic logic csr_is_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE, CSR_MINSTRET: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_regfile_counter.sv
// Free-running counter with an increment enable; a load in the same cycle
// wins over the increment. Wraps naturally at 2^WIDTH.
module csr_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_value;
        end else if (inc_en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: combinational read with write bypass,
// writeback commit, trap entry, mret return, counters and timer-pending.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csr_readaddr_i,
    output logic [XLEN-1:0] csr_readdata_o,
    output logic            csr_illegal_o,
    input  logic            csr_writevalid_i,
    input  logic [11:0]     csr_writeaddr_i,
    input  logic [XLEN-1:0] csr_writedata_i,
    input  logic            retire_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            irq_timer_i,
    output logic            irq_pending_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    logic            mst_mie;
    logic            mst_mpie;
    logic            mie_mtie;
    logic            mip_mtip;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mcycle_q;
    logic [XLEN-1:0] minstret_q;
    logic [XLEN-1:0] wdata_masked;
    logic [XLEN-1:0] misa_value;
    logic            wr_en;

    assign misa_value = MISA_VALUE[XLEN-1:0];

    // Trap and mret both outrank a writeback in the same cycle.
    assign wr_en = csr_writevalid_i & ~trap_valid_i & ~mret_i;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wdata_masked = csr_writedata_i;
        case (csr_writeaddr_i)
            CSR_MSTATUS: begin
                wdata_masked                                 = '0;
                wdata_masked[MSTATUS_MIE_BIT]                = csr_writedata_i[MSTATUS_MIE_BIT];
                wdata_masked[MSTATUS_MPIE_BIT]               = csr_writedata_i[MSTATUS_MPIE_BIT];
                wdata_masked[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB] = 2'b11;
            end
            CSR_MIE: begin
                wdata_masked               = '0;
                wdata_masked[MIE_MTIE_BIT] = csr_writedata_i[MIE_MTIE_BIT];
            end
            CSR_MTVEC, CSR_MEPC: wdata_masked[1:0] = 2'b00;
            default: ;
        endcase
    end

    always_comb begin
        csr_readdata_o = '0;
        csr_illegal_o  = 1'b0;
        case (csr_readaddr_i)
            CSR_MSTATUS: begin
                csr_readdata_o[MSTATUS_MIE_BIT]                   = mst_mie;
                csr_readdata_o[MSTATUS_MPIE_BIT]                  = mst_mpie;
                csr_readdata_o[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB] = 2'b11;
            end
            CSR_MISA:     csr_readdata_o = misa_value;
            CSR_MIE:      csr_readdata_o[MIE_MTIE_BIT] = mie_mtie;
            CSR_MTVEC:    csr_readdata_o = mtvec_q;
            CSR_MSCRATCH: csr_readdata_o = mscratch_q;
            CSR_MEPC:     csr_readdata_o = mepc_q;
            CSR_MCAUSE:   csr_readdata_o = mcause_q;
            CSR_MTVAL:    csr_readdata_o = mtval_q;
            CSR_MIP:      csr_readdata_o[MIP_MTIP_BIT] = mip_mtip;
            CSR_MCYCLE:   csr_readdata_o = mcycle_q;
            CSR_MINSTRET: csr_readdata_o = minstret_q;
            CSR_MHARTID:  csr_readdata_o = '0;
            default:      csr_illegal_o  = 1'b1;
        endcase
        // Bypass only what will actually commit, so read-only CSRs keep their value.
        if (wr_en && csr_writeaddr_i == csr_readaddr_i && csr_is_writable(csr_writeaddr_i)) begin
            csr_readdata_o = wdata_masked;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie          <= 1'b0;
            mst_mpie         <= 1'b0;
            mie_mtie         <= 1'b0;
            mip_mtip         <= 1'b0;
            mtvec_q          <= '0;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            irq_pending_o    <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            mip_mtip         <= irq_timer_i;
            irq_pending_o    <= mst_mie & mie_mtie & mip_mtip;
            redirect_valid_o <= trap_valid_i | mret_i;
            if (trap_valid_i) begin
                mepc_q        <= {trap_pc_i[XLEN-1:2], 2'b00};
                mcause_q      <= trap_cause_i;
                mtval_q       <= trap_tval_i;
                mst_mpie      <= mst_mie;
                mst_mie       <= 1'b0;
                redirect_pc_o <= mtvec_q;
            end else if (mret_i) begin
                mst_mie       <= mst_mpie;
                mst_mpie      <= 1'b1;
                redirect_pc_o <= mepc_q;
            end else if (wr_en) begin
                case (csr_writeaddr_i)
                    CSR_MSTATUS: begin
                        mst_mie  <= wdata_masked[MSTATUS_MIE_BIT];
                        mst_mpie <= wdata_masked[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:      mie_mtie   <= wdata_masked[MIE_MTIE_BIT];
                    CSR_MTVEC:    mtvec_q    <= wdata_masked;
                    CSR_MSCRATCH: mscratch_q <= wdata_masked;
                    CSR_MEPC:     mepc_q     <= wdata_masked;
                    CSR_MCAUSE:   mcause_q   <= wdata_masked;
                    CSR_MTVAL:    mtval_q    <= wdata_masked;
                    default: ;
                endcase
            end
        end
    end

    csr_counter #(.WIDTH(XLEN)) u_mcycle (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_en     (1'b1),
        .load_en    (wr_en && csr_writeaddr_i == CSR_MCYCLE),
        .load_value (wdata_masked),
        .count      (mcycle_q)
    );

    csr_counter #(.WIDTH(XLEN)) u_minstret (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_en     (retire_i & ~trap_valid_i),
        .load_en    (wr_en && csr_writeaddr_i == CSR_MINSTRET),
        .load_value (wdata_masked),
        .count      (minstret_q)
    );

endmodule
